// File: rtl/prewish_pkg.sv
// Shared constants for the prewish mentor/blinker strobe link.
// Mask width, FSM encoding and the default prescaler divide.
package prewish_pkg;

  localparam int MASK_W       = 8;
  localparam int IDX_W        = $clog2(MASK_W);
  localparam int TICK_DIV_DEF = 3_000_000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/prewish_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and pulses o_tick on the last count.
// Disabled or cleared holds the count at 0; a clear suppresses the tick of that cycle.
module prewish_tick_gen #(
  parameter int TICK_DIV = prewish_pkg::TICK_DIV_DEF
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en & ~i_clr & w_last;

endmodule

// File: rtl/prewish_mask_blinker.sv
// Plays an 8-bit strobed mask on one LED, MSB first, TICK_DIV cycles per bit, repeating.
// Load takes effect after the detecting edge; ACK_O pulses for one cycle per rising STB_I.
module prewish_mask_blinker
  import prewish_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [MASK_W-1:0] DAT_I,
  output logic              ACK_O,
  output logic              LED_O,
  output logic              RUN_O
);

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MASK_W - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_stb_d;
  logic              r_armed;
  logic              r_ack;
  logic [MASK_W-1:0] r_mask;
  logic [IDX_W-1:0]  r_idx;
  logic              w_load;
  logic              w_tick;
  logic              w_led;
  logic              w_run;

  // r_armed blocks a strobe that was already high when reset released.
  assign w_load = STB_I & ~r_stb_d & r_armed;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_stb_d <= 1'b0;
      r_armed <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_stb_d <= STB_I;
      r_armed <= r_armed | ~STB_I;
      r_ack   <= w_load;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_mask <= '0;
      r_idx  <= IDX_TOP;
    end else if (w_load) begin
      r_mask <= DAT_I;
      r_idx  <= IDX_TOP;
    end else if (w_tick) begin
      r_idx  <= r_idx - 1'b1;
    end
  end

  prewish_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .i_en   (r_state == ST_RUN),
    .i_clr  (w_load),
    .o_tick (w_tick)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = (DAT_I != '0) ? ST_RUN : ST_IDLE;
    end
  end

  always_comb begin
    w_run = 1'b0;
    w_led = 1'b0;
    if (r_state == ST_RUN) begin
      w_run = 1'b1;
      w_led = r_mask[r_idx];
    end
  end

  assign ACK_O = r_ack;
  assign LED_O = w_led;
  assign RUN_O = w_run;

endmodule

// File: tb/tb_prewish_mask_blinker.sv
// Scoreboard bench for prewish_mask_blinker with TICK_DIV = 4.
module tb_prewish_mask_blinker;

  localparam int TD = 4;

  typedef struct packed {
    logic ack;
    logic led;
    logic run;
  } exp_t;

  logic       CLK_I;
  logic       RST_I;
  logic       STB_I;
  logic [7:0] DAT_I;
  logic       ACK_O;
  logic       LED_O;
  logic       RUN_O;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  prewish_mask_blinker #(
    .TICK_DIV (TD)
  ) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .STB_I (STB_I),
    .DAT_I (DAT_I),
    .ACK_O (ACK_O),
    .LED_O (LED_O),
    .RUN_O (RUN_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // Advance past the next rising edge; outputs then reflect that edge.
  task automatic cyc();
    @(posedge CLK_I);
    #2;
  endtask

  // Expected outputs for n cycles starting at the load edge (t = 0).
  function automatic void sb_push_run(input logic [7:0] mask, input int n);
    exp_t       e;
    logic [7:0] m;
    m = mask;
    for (int t = 0; t < n; t++) begin
      e.ack = (t == 0);
      e.run = (m != 8'h00);
      e.led = e.run & m[7 - ((t / TD) % 8)];
      sb_q.push_back(e);
    end
  endfunction

  function automatic void sb_push_idle(input int n);
    for (int t = 0; t < n; t++) sb_q.push_back(3'b000);
  endfunction

  task automatic test_reset();
    RST_I = 1'b0;
    STB_I = 1'b0;
    DAT_I = 8'h00;
    cyc();
    cyc();
    n_cmp++;
    if (ACK_O !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", ACK_O); end
    n_cmp++;
    if (LED_O !== 1'b0) begin n_bad++; $display("FAIL reset_led got=%b exp=0", LED_O); end
    n_cmp++;
    if (RUN_O !== 1'b0) begin n_bad++; $display("FAIL reset_run got=%b exp=0", RUN_O); end
    RST_I = 1'b1;
    cyc();
    n_cmp++;
    if ({ACK_O, LED_O, RUN_O} !== 3'b000) begin
      n_bad++; $display("FAIL reset_idle ack/led/run got=%b exp=000", {ACK_O, LED_O, RUN_O});
    end
  endtask

  task automatic test_basic_pattern();
    exp_t e;
    STB_I = 1'b1; DAT_I = 8'b1010_0000;
    cyc();
    STB_I = 1'b0;
    sb_push_run(8'b1010_0000, 70);
    for (int t = 0; t < 70; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL basic_pattern t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      cyc();
    end
  endtask

  task automatic test_held_strobe();
    exp_t e;
    STB_I = 1'b1; DAT_I = 8'hFF;
    cyc();
    sb_push_run(8'hFF, 16);
    for (int t = 0; t < 16; t++) begin
      if (t == 9) STB_I = 1'b0;
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL held_strobe t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      cyc();
    end
  endtask

  task automatic test_restrobe();
    exp_t e;
    STB_I = 1'b1; DAT_I = 8'hA5;
    cyc();
    STB_I = 1'b0;
    sb_push_run(8'hA5, 11);
    for (int t = 0; t < 11; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL restrobe_old t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      // t = 10 is bit 5, prescaler phase 2
      if (t == 10) begin STB_I = 1'b1; DAT_I = 8'h01; end
      cyc();
    end
    STB_I = 1'b0;
    sb_push_run(8'h01, 40);
    for (int t = 0; t < 40; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL restrobe_new t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      cyc();
    end
  endtask

  task automatic test_zero_mask();
    exp_t e;
    STB_I = 1'b1; DAT_I = 8'h00;
    cyc();
    STB_I = 1'b0;
    sb_push_run(8'h00, 10);
    for (int t = 0; t < 10; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL zero_mask t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      cyc();
    end
  endtask

  task automatic test_wrap_collision();
    exp_t e;
    STB_I = 1'b1; DAT_I = 8'h40;
    cyc();
    STB_I = 1'b0;
    sb_push_run(8'h40, 4);
    for (int t = 0; t < 4; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL wrap_old t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      // t = 3 is the prescaler's last count: the next edge would tick
      if (t == 3) begin STB_I = 1'b1; DAT_I = 8'h80; end
      cyc();
    end
    STB_I = 1'b0;
    sb_push_run(8'h80, 12);
    for (int t = 0; t < 12; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL wrap_new t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    STB_I = 1'b1; DAT_I = 8'hF0;
    cyc();
    STB_I = 1'b0;
    sb_push_run(8'hF0, 2);
    for (int t = 0; t < 2; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL b2b_first t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      if (t == 1) begin STB_I = 1'b1; DAT_I = 8'h0F; end
      cyc();
    end
    STB_I = 1'b0;
    sb_push_run(8'h0F, 20);
    for (int t = 0; t < 20; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL b2b_second t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    STB_I = 1'b1; DAT_I = 8'hFF;
    cyc();
    cyc();
    cyc();
    // STB_I stays high through the reset pulse
    RST_I = 1'b0;
    #1;
    n_cmp++;
    if ({ACK_O, LED_O, RUN_O} !== 3'b000) begin
      n_bad++; $display("FAIL reset_async ack/led/run got=%b exp=000", {ACK_O, LED_O, RUN_O});
    end
    cyc();
    RST_I = 1'b1;
    sb_push_idle(6);
    for (int t = 0; t < 6; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL reset_no_load t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      cyc();
    end
    STB_I = 1'b0;
    cyc();
    STB_I = 1'b1; DAT_I = 8'hFF;
    cyc();
    STB_I = 1'b0;
    sb_push_run(8'hFF, 6);
    for (int t = 0; t < 6; t++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ACK_O, LED_O, RUN_O} !== e) begin
        n_bad++; $display("FAIL reset_reload t=%0d ack/led/run got=%b exp=%b", t, {ACK_O, LED_O, RUN_O}, e);
      end
      cyc();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST_I = 1'b0;
    STB_I = 1'b0;
    DAT_I = 8'h00;
    test_reset();
    test_basic_pattern();
    test_held_strobe();
    test_restrobe();
    test_zero_mask();
    test_wrap_collision();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prewish_mask_blinker.md
# prewish_mask_blinker

Receiving end of the prewish mentor strobe/data link. It accepts an 8-bit blink mask when STB_I is asserted and plays it on a single LED, MSB first, one bit per prescaled tick. The pattern repeats until a new mask or reset arrives. It sits between the mentor (the strobe initiator) and the board LED pin, and is the first consumer of the mentor's STB/DAT interface.

## Interface
Parameters:
- TICK_DIV, default 3_000_000: clock cycles per mask bit (0.25 s at 12 MHz). Legal range is ≥ 2. Benches use 4.
- MASK_W, default 8: mask width. Fixed at 8 for this revision; taken from the package.

Ports:
- CLK_I  in  1  system clock; single clock domain.
- RST_I  in  1  reset, asynchronous, active-low.
- STB_I  in  1  mask strobe from the mentor; only its rising edge is significant.
- DAT_I  in  8  blink mask; sampled on the same CLK_I edge that detects the STB_I rise.
- ACK_O  out 1  one-cycle pulse confirming a mask was captured.
- LED_O  out 1  LED drive, active-high.
- RUN_O  out 1  high while a nonzero mask is playing.

## Operation
- Reset (RST_I low, asynchronous) clears all state:
  - state = IDLE, mask = 0, bit index = 7, prescaler = 0, strobe history = 0.
  - ACK_O = 0, LED_O = 0, RUN_O = 0.
- Strobe detect: a one-bit register holds the previous STB_I. A load occurs on any edge where STB_I = 1 and the held value = 0. A STB_I held high for N cycles produces exactly one load.
- States:
  - IDLE: LED_O = 0, prescaler held at 0. A load with DAT_I ≠ 0 goes to RUN. A load with DAT_I = 0 stays in IDLE.
  - RUN: the prescaler counts 0 … TICK_DIV-1. On reaching TICK_DIV-1 it wraps to 0 and the bit index decrements, wrapping from 0 back to 7. A load with DAT_I ≠ 0 reloads the mask and restarts at bit 7 with prescaler = 0. A load with DAT_I = 0 goes to IDLE.
- Load action, in all cases: mask ← DAT_I, bit index ← 7, prescaler ← 0, ACK_O ← 1 for exactly one cycle.
- LED_O = (state == RUN) & mask[bit index]. It is a function of registers only; there is no combinational path from STB_I or DAT_I.
- RUN_O = (state == RUN).

## Timing
- Load latency: STB_I rise sampled at edge k.
  - After edge k: ACK_O = 1, LED_O = DAT_I[7], RUN_O = 1 (if DAT_I ≠ 0).
  - After edge k+1: ACK_O = 0.
- Bit period: each mask bit is shown for exactly TICK_DIV cycles. Bit 6 appears after edge k+TICK_DIV.
- Full pattern period: 8 × TICK_DIV cycles. Wrap from bit 0 to bit 7 has no gap cycle.
- Re-strobe mid-pattern: the new mask takes effect after the detecting edge, regardless of prescaler phase. The old pattern is truncated with no glitch beyond the bit change itself.
- Strobe coincident with prescaler wrap: the load wins. Index = 7, prescaler = 0.
- Reset mid-pattern: outputs go to reset values immediately (asynchronously). After RST_I deasserts, the block waits in IDLE for a fresh strobe; a STB_I already high at deassertion is not a rising edge until it falls and rises again.
- Counter width: $clog2(TICK_DIV) bits. Index width: 3 bits. No other arithmetic.

## Structure
- Shared package prewish_pkg holds:
  - MASK_W = 8.
  - The state encoding: IDLE = 1'b0, RUN = 1'b1.
  - The default TICK_DIV constant, shared with the mentor and top level.
- Sub-module prewish_tick_gen (prescaler) takes CLK_I, RST_I, an enable, and a synchronous clear. It outputs a one-cycle tick on count TICK_DIV-1. The blinker drives enable = RUN and clear = load.
- Top-level FSM, strobe edge detect, mask register and index counter live in prewish_mask_blinker.

## Test plan
- Reset then one-cycle strobe, DAT_I = 8'b10100000, TICK_DIV = 4 → ACK_O pulse 1 cycle after the load edge. LED_O sequence is 1 for 4 cycles, 0 for 4, 1 for 4, then 0 for 20, repeating with period 32. RUN_O stays 1.
- STB_I held high 10 cycles, DAT_I = 8'hFF → exactly one ACK_O pulse; LED_O constantly 1.
- Mid-pattern re-strobe at bit 5, prescaler phase 2, DAT_I = 8'h01 → next cycle LED_O = 0 (bit 7 of new mask). LED_O = 1 only in the cycle window 28–31 after the load.
- Strobe with DAT_I = 8'h00 while running → ACK_O pulses; RUN_O and LED_O are 0 from the next cycle onward.
- RST_I pulled low for 1 cycle during RUN with STB_I held high → outputs are 0 asynchronously. After release, no load occurs until STB_I toggles low then high.
- Strobe landing on the prescaler wrap cycle → index resets to 7. The first new bit lasts a full 4 cycles.
